// File: rtl/mstatus_seq_pkg.sv
// Shared mstatus field layout, privilege encodings and packing/legalisation helpers.
package mstatus_seq_pkg;

    localparam logic [1:0] PRV_U = 2'd0;
    localparam logic [1:0] PRV_S = 2'd1;
    localparam logic [1:0] PRV_M = 2'd3;

    localparam logic [1:0] XL_64 = 2'b10;

    localparam int SIE_BIT  = 1;
    localparam int MIE_BIT  = 3;
    localparam int SPIE_BIT = 5;
    localparam int MPIE_BIT = 7;
    localparam int SPP_BIT  = 8;
    localparam int MPP_LSB  = 11;
    localparam int FS_LSB   = 13;
    localparam int MPRV_BIT = 17;
    localparam int SUM_BIT  = 18;
    localparam int MXR_BIT  = 19;
    localparam int TVM_BIT  = 20;
    localparam int TW_BIT   = 21;
    localparam int TSR_BIT  = 22;
    localparam int UXL_LSB  = 32;
    localparam int SXL_LSB  = 34;
    localparam int SD_BIT   = 63;

    typedef struct packed {
        logic       tsr;
        logic       tw;
        logic       tvm;
        logic       mxr;
        logic       sum;
        logic       mprv;
        logic [1:0] fs;
        logic [1:0] mpp;
        logic       spp;
        logic       mpie;
        logic       spie;
        logic       mie;
        logic       sie;
    } mstatus_fields_t;

    localparam mstatus_fields_t FIELDS_RST = '{mpp: PRV_M, default: '0};

    // sxl/uxl are hardwired to 64-bit and sd is derived from fs, never stored.
    function automatic logic [63:0] pack_mstatus(input mstatus_fields_t f);
        logic [63:0] w;
        w = '0;
        w[SIE_BIT]        = f.sie;
        w[MIE_BIT]        = f.mie;
        w[SPIE_BIT]       = f.spie;
        w[MPIE_BIT]       = f.mpie;
        w[SPP_BIT]        = f.spp;
        w[MPP_LSB +: 2]   = f.mpp;
        w[FS_LSB +: 2]    = f.fs;
        w[MPRV_BIT]       = f.mprv;
        w[SUM_BIT]        = f.sum;
        w[MXR_BIT]        = f.mxr;
        w[TVM_BIT]        = f.tvm;
        w[TW_BIT]         = f.tw;
        w[TSR_BIT]        = f.tsr;
        w[UXL_LSB +: 2]   = XL_64;
        w[SXL_LSB +: 2]   = XL_64;
        w[SD_BIT]         = (f.fs == 2'b11);
        return w;
    endfunction

    function automatic mstatus_fields_t csr_write_fields(input mstatus_fields_t old,
                                                         input logic [63:0] w);
        mstatus_fields_t f;
        f.sie  = w[SIE_BIT];
        f.mie  = w[MIE_BIT];
        f.spie = w[SPIE_BIT];
        f.mpie = w[MPIE_BIT];
        f.spp  = w[SPP_BIT];
        f.mpp  = (w[MPP_LSB +: 2] == 2'b10) ? old.mpp : w[MPP_LSB +: 2];
        f.fs   = w[FS_LSB +: 2];
        f.mprv = w[MPRV_BIT];
        f.sum  = w[SUM_BIT];
        f.mxr  = w[MXR_BIT];
        f.tvm  = w[TVM_BIT];
        f.tw   = w[TW_BIT];
        f.tsr  = w[TSR_BIT];
        return f;
    endfunction

endpackage

// File: rtl/mstatus_trace_fifo.sv
// Generic synchronous FIFO; an extra pointer bit distinguishes full from empty.
module mstatus_trace_fifo #(
    parameter int DATA_W = 66,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic              do_push, do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    // A pop frees the head slot in the same cycle, so a push into a full FIFO still lands.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q + (do_push ? 1'b1 : 1'b0);
        rd_ptr_d = rd_ptr_q + (do_pop ? 1'b1 : 1'b0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/mstatus_seq_ctrl.sv
// Owns mstatus and the hart privilege; arbitrates updates and streams snapshots on change.
module mstatus_seq_ctrl
    import mstatus_seq_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int TRACE_DEPTH = 4,
    parameter int DROP_CNT_W  = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  trap_valid,
    input  logic                  trap_to_s,
    input  logic                  mret,
    input  logic                  sret,
    input  logic                  csr_wen,
    input  logic [XLEN-1:0]       csr_wdata,
    input  logic                  fs_dirty,
    output logic [XLEN-1:0]       mstatus,
    output logic [1:0]            prv,
    output logic                  trace_valid,
    input  logic                  trace_ready,
    output logic [XLEN+1:0]       trace_data,
    output logic [DROP_CNT_W-1:0] trace_drops
);
    mstatus_fields_t       fields_q, fields_d;
    logic [1:0]            prv_q, prv_d;
    logic [XLEN+1:0]       snap_prev_q, snap_cur;
    logic [DROP_CNT_W-1:0] drops_q, drops_d;
    logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;

    assign mstatus     = pack_mstatus(fields_q);
    assign prv         = prv_q;
    assign snap_cur    = {prv_q, mstatus};
    assign trace_valid = !fifo_empty;
    assign trace_drops = drops_q;
    assign fifo_push   = (snap_cur != snap_prev_q);
    assign fifo_pop    = trace_valid && trace_ready;

    always_comb begin
        fields_d = fields_q;
        prv_d    = prv_q;
        if (trap_valid) begin
            // Delegation to S never lowers an M-mode hart.
            if (trap_to_s && (prv_q != PRV_M)) begin
                fields_d.spie = fields_q.sie;
                fields_d.sie  = 1'b0;
                fields_d.spp  = prv_q[0];
                prv_d         = PRV_S;
            end else begin
                fields_d.mpie = fields_q.mie;
                fields_d.mie  = 1'b0;
                fields_d.mpp  = prv_q;
                prv_d         = PRV_M;
            end
        end else if (mret) begin
            fields_d.mie  = fields_q.mpie;
            fields_d.mpie = 1'b1;
            fields_d.mpp  = PRV_U;
            prv_d         = fields_q.mpp;
            if (fields_q.mpp != PRV_M) fields_d.mprv = 1'b0;
        end else if (sret) begin
            fields_d.sie  = fields_q.spie;
            fields_d.spie = 1'b1;
            fields_d.spp  = 1'b0;
            fields_d.mprv = 1'b0;
            prv_d         = {1'b0, fields_q.spp};
        end else begin
            if (csr_wen) fields_d = csr_write_fields(fields_q, csr_wdata);
            if (fs_dirty) fields_d.fs = 2'b11;
        end
    end

    always_comb begin
        drops_d = drops_q;
        if (fifo_push && fifo_full && !fifo_pop && (drops_q != {DROP_CNT_W{1'b1}}))
            drops_d = drops_q + 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fields_q    <= FIELDS_RST;
            prv_q       <= PRV_M;
            snap_prev_q <= {PRV_M, pack_mstatus(FIELDS_RST)};
            drops_q     <= '0;
        end else begin
            fields_q    <= fields_d;
            prv_q       <= prv_d;
            snap_prev_q <= snap_cur;
            drops_q     <= drops_d;
        end
    end

    mstatus_trace_fifo #(
        .DATA_W (XLEN + 2),
        .DEPTH  (TRACE_DEPTH)
    ) u_trace_fifo (
        .clk   (clock),
        .rst   (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (snap_cur),
        .dout  (trace_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule
